// File: rtl/nes_pad_poller.sv
// ---------------------------------------------------------------------------
// nes_pad_poller
//
// Polls NUM_PADS NES controllers that share one latch line and one shift-clock
// line. Each controller has its own serial data line. A scan starts once every
// POLL_CYCLES clocks. One scan is:
//   latch high (2*PULSE_CYCLES)
//   8 x clock-low windows, with 7 clock-high windows between them
//   one DONE cycle that publishes the frame
// The published button state is therefore stable for a whole frame.
//
// Optional feature (macro COMBO_RESET_EN):
//   When defined, the poller raises nes_reset once pad 0 has held
//   A+B+Select+Start for HOLD_FRAMES consecutive frames.
//   When undefined, nes_reset is tied low.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   nes_data     per-pad serial data, active-low (0 = pressed)
//   nes_latch    shared latch strobe, active-high, registered
//   nes_clk      shared shift clock, idles low, registered
//   buttons      held state, pad p at [8p+7:8p]
//                bit order: A,B,Select,Start,Up,Down,Left,Right = bits 0..7
//   pressed      one-cycle pulse for buttons that are newly pressed this frame
//   frame_valid  one-cycle pulse when buttons/pressed update
//   nes_reset    combo soft-reset request, active-high
// ---------------------------------------------------------------------------
module nes_pad_poller #(
    parameter int NUM_PADS     = 2,
    parameter int POLL_CYCLES  = 833333,
    parameter int PULSE_CYCLES = 300,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PADS-1:0]   nes_data,
    output logic                  nes_latch,
    output logic                  nes_clk,
    output logic [8*NUM_PADS-1:0] buttons,
    output logic [8*NUM_PADS-1:0] pressed,
    output logic                  frame_valid,
    output logic                  nes_reset
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = $clog2(2 * PULSE_CYCLES + 1);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * PULSE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);

    // Reject parameter sets that cannot work.
    // A scan must finish before the next poll tick, otherwise scans would
    // be silently skipped.
    if (17 * PULSE_CYCLES + 1 >= POLL_CYCLES) begin : g_scan_too_long
        $error("nes_pad_poller: scan length 17*PULSE_CYCLES+1 must be < POLL_CYCLES");
    end
    if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pad_count
        $error("nes_pad_poller: NUM_PADS must be 1..4");
    end
    if (PULSE_CYCLES < 1 || HOLD_FRAMES < 1) begin : g_bad_timing
        $error("nes_pad_poller: PULSE_CYCLES and HOLD_FRAMES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t                  state_reg;
    logic [PW-1:0]           poll_reg;
    logic [TW-1:0]           timer_reg;
    logic [2:0]              bit_idx_reg;
    logic [8*NUM_PADS-1:0]   shift_reg;
    logic [NUM_PADS-1:0]     sync1_reg;
    logic [NUM_PADS-1:0]     sync2_reg;

    // Free-running poll timebase. Scans are launched when it reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_reg <= '0;
        end else if (poll_reg == POLL_LAST) begin
            poll_reg <= '0;
        end else begin
            poll_reg <= poll_reg + PW'(1);
        end
    end

    // The pad data lines are asynchronous to clk, so they are synchronised
    // through two flops here.
    // Reset value is 1 (line idle / released), so a pad can never read as
    // pressed out of reset.
    // The two-cycle delay is far shorter than a clock-low window. When the
    // sample is taken at the end of the window, the line has long since
    // settled on the current bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= nes_data;
            sync2_reg <= sync1_reg;
        end
    end

    // Scan sequencer. Every output is a flop, so latch and clock are
    // glitch-free. The state machine guarantees they are never high together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            nes_latch   <= 1'b0;
            nes_clk     <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            frame_valid <= 1'b0;
        end else begin
            pressed     <= '0;
            frame_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (poll_reg == '0) begin
                        state_reg <= LATCH;
                        nes_latch <= 1'b1;
                        timer_reg <= '0;
                    end
                end
                LATCH: begin
                    if (timer_reg == LATCH_LAST) begin
                        state_reg   <= LOW;
                        nes_latch   <= 1'b0;
                        timer_reg   <= '0;
                        bit_idx_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                LOW: begin
                    if (timer_reg == PULSE_LAST) begin
                        // Invert on capture: the line is active-low, the
                        // published state is active-high.
                        for (int p = 0; p < NUM_PADS; p++) begin
                            shift_reg[8*p + int'(bit_idx_reg)] <= ~sync2_reg[p];
                        end
                        timer_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= HIGH;
                            nes_clk   <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                HIGH: begin
                    if (timer_reg == PULSE_LAST) begin
                        state_reg   <= LOW;
                        nes_clk     <= 1'b0;
                        timer_reg   <= '0;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                DONE: begin
                    buttons     <= shift_reg;
                    pressed     <= shift_reg & ~buttons;
                    frame_valid <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    nes_latch <= 1'b0;
                    nes_clk   <= 1'b0;
                end
            endcase
        end
    end

`ifdef COMBO_RESET_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    logic [HW-1:0] hold_reg;
    logic [HW-1:0] hold_next;

    // The combo is judged on the frame just scanned: A, B, Select and Start
    // are pad-0 bits 0..3.
    // The count saturates, so nes_reset stays asserted for as long as the
    // combo is held.
    always_comb begin
        hold_next = hold_reg;
        if (&shift_reg[3:0]) begin
            if (hold_reg != HOLD_MAX) begin
                hold_next = hold_reg + HW'(1);
            end
        end else begin
            hold_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg  <= '0;
            nes_reset <= 1'b0;
        end else if (state_reg == DONE) begin
            hold_reg  <= hold_next;
            nes_reset <= (hold_next == HOLD_MAX);
        end
    end
`else
    assign nes_reset = 1'b0;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// ---------------------------------------------------------------------------
// tb_nes_pad_poller
//
// Directed bench for nes_pad_poller.
// Parameters: NUM_PADS=2, POLL_CYCLES=100, PULSE_CYCLES=2, HOLD_FRAMES=3.
//
// A small pad model answers the latch/clock strobes:
//   - latch resets the bit index to 0
//   - each rising nes_clk advances the bit index by one
//   - an unplugged pad holds its line at 1
//
// Cycle k is counted from the first clock edge after reset is released.
// Outputs are sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_nes_pad_poller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  nes_data;
    logic        nes_latch;
    logic        nes_clk;
    logic [15:0] buttons;
    logic [15:0] pressed;
    logic        frame_valid;
    logic        nes_reset;

    logic [7:0]  pad_btn [2];
    logic [1:0]  unplugged = 2'b00;
    logic [3:0]  pad_idx = 4'd0;
    logic        clk_d = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    nes_pad_poller #(
        .NUM_PADS    (2),
        .POLL_CYCLES (100),
        .PULSE_CYCLES(2),
        .HOLD_FRAMES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nes_data   (nes_data),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .buttons    (buttons),
        .pressed    (pressed),
        .frame_valid(frame_valid),
        .nes_reset  (nes_reset)
    );

    // Pad model: a 4021-style shift register on each controller.
    always @(posedge clk) begin
        clk_d <= nes_clk;
        if (nes_latch) begin
            pad_idx <= 4'd0;
        end else if (nes_clk && !clk_d && pad_idx < 4'd8) begin
            pad_idx <= pad_idx + 4'd1;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (unplugged[p]) begin
                nes_data[p] = 1'b1;
            end else if (pad_idx < 4'd8) begin
                nes_data[p] = ~pad_btn[p][pad_idx[2:0]];
            end else begin
                nes_data[p] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        logic exp_clk;
        pad_btn[0] = 8'h81;   // A + Right
        pad_btn[1] = 8'h08;   // Start

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_latch",   nes_latch,   0);
        chk("rst_clk",     nes_clk,     0);
        chk("rst_buttons", buttons,     0);
        chk("rst_pressed", pressed,     0);
        chk("rst_fv",      frame_valid, 0);
        chk("rst_nreset",  nes_reset,   0);

        // Release reset at a falling edge; the next falling edge is cycle 0.
        reset = 1'b1;
        cyc = -1;

        // Frame 1 strobe timing: latch on cycles 0..3.
        // Bit i is sampled in the low window at 4+4i..5+4i.
        // The high window follows at 6+4i..7+4i, for bits 0..6.
        for (int k = 0; k < 35; k++) begin
            tick();
            exp_clk = (cyc >= 6 && cyc <= 31 && ((cyc - 4) % 4) >= 2);
            chk("f1_latch", nes_latch, (cyc < 4));
            chk("f1_clk",   nes_clk,   exp_clk);
            chk("f1_fv",    frame_valid, 0);
        end
        tick();   // cycle 35
        chk("f1_fv_pulse", frame_valid, 1);
        chk("f1_buttons",  buttons,     16'h0881);
        chk("f1_pressed",  pressed,     16'h0881);
        tick();   // cycle 36
        chk("f1_fv_end",      frame_valid, 0);
        chk("f1_pressed_end", pressed,     16'h0000);
        chk("f1_buttons_hold", buttons,    16'h0881);
        run_to(99);
        chk("latch_before_100", nes_latch, 0);
        tick();
        chk("latch_at_100", nes_latch, 1);

        // Frame 2: same stimulus, so nothing is newly pressed.
        run_to(134);
        chk("f2_fv_pre", frame_valid, 0);
        tick();
        chk("f2_fv",      frame_valid, 1);
        chk("f2_buttons", buttons,     16'h0881);
        chk("f2_pressed", pressed,     16'h0000);

        // Frame 3: A released on pad 0.
        pad_btn[0] = 8'h80;
        run_to(235);
        chk("f3_fv",      frame_valid, 1);
        chk("f3_buttons", buttons,     16'h0880);
        chk("f3_pressed", pressed,     16'h0000);

        // Frame 4: A newly pressed on pad 1.
        pad_btn[1] = 8'h09;
        run_to(335);
        chk("f4_fv",      frame_valid, 1);
        chk("f4_buttons", buttons,     16'h0980);
        chk("f4_pressed", pressed,     16'h0100);

        // Frame 5: reset during the high window of bit 3 (cycles 418..419).
        run_to(418);
        chk("mid_clk_high", nes_clk, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_latch",   nes_latch, 0);
        chk("mid_rst_clk",     nes_clk,   0);
        chk("mid_rst_buttons", buttons,   16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cyc = -1;
        for (int k = 0; k < 35; k++) begin
            tick();
            chk("post_rst_fv",      frame_valid, 0);
            chk("post_rst_buttons", buttons,     16'h0000);
        end
        tick();   // cycle 35 of the fresh scan
        chk("post_rst_fv_pulse", frame_valid, 1);
        chk("post_rst_buttons1", buttons,     16'h0980);
        chk("post_rst_pressed1", pressed,     16'h0980);

        // Both pads unplugged: all buttons released, frames still tick.
        unplugged = 2'b11;
        run_to(135);
        chk("unpl_fv",      frame_valid, 1);
        chk("unpl_buttons", buttons,     16'h0000);
        chk("unpl_pressed", pressed,     16'h0000);
        run_to(234);
        chk("unpl_fv_gap", frame_valid, 0);
        tick();
        chk("unpl_fv2",      frame_valid, 1);
        chk("unpl_buttons2", buttons,     16'h0000);

        // Combo: pad 0 holds A, B, Select and Start.
        unplugged  = 2'b00;
        pad_btn[0] = 8'h0F;
        pad_btn[1] = 8'h00;
        run_to(335);
        chk("combo_buttons", buttons,   16'h000F);
        chk("combo_pressed", pressed,   16'h000F);
        chk("combo_f1",      nes_reset, 0);
        run_to(435);
        chk("combo_f2", nes_reset, 0);
        run_to(534);
        chk("combo_pre_f3", nes_reset, 0);
        tick();
`ifdef COMBO_RESET_EN
        chk("combo_f3", nes_reset, 1);
`else
        chk("combo_f3", nes_reset, 0);
`endif
        // Releasing Select drops the request at the next frame.
        pad_btn[0] = 8'h0B;
        run_to(634);
`ifdef COMBO_RESET_EN
        chk("combo_hold", nes_reset, 1);
`else
        chk("combo_hold", nes_reset, 0);
`endif
        tick();
        chk("combo_rel",         nes_reset, 0);
        chk("combo_rel_buttons", buttons,   16'h000B);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
